// File: rtl/home_event_scheduler.sv
// home_event_scheduler: debounced sensors + temperature hysteresis arbitrated by fixed priority with minimum hold.
// Optional ALARM_LATCH_EN keeps ALARM latched until alarm_ack while the debounced fire sensor is low.
module home_event_scheduler #(
   parameter int         DEB      = 3,
   parameter int         MIN_HOLD = 8,
   parameter logic [6:0] TEMP_LO  = 7'd50,
   parameter logic [6:0] TEMP_HI  = 7'd70,
   parameter int         HYST     = 2
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic       SFD,
   input  logic       SRD,
   input  logic       SW,
   input  logic       SFA,
   input  logic [6:0] ST,
`ifdef ALARM_LATCH_EN
   input  logic       alarm_ack,
`endif
   output logic       fdoor,
   output logic       rdoor,
   output logic       winbuzz,
   output logic       alarmbuzz,
   output logic       heater,
   output logic       cooler,
   output logic [2:0] display,
   output logic       grant_chg,
   output logic       hold_active
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_FDOOR = 3'd1, S_RDOOR = 3'd2, S_ALARM = 3'd3,
      S_WINDOW = 3'd4, S_HEAT = 3'd5, S_COOL = 3'd6, S_BAD = 3'd7
   } state_t;

   localparam logic [3:0] DEB_LAST  = 4'(DEB - 1);
   localparam logic [7:0] HOLD_LOAD = 8'(MIN_HOLD - 1);
   localparam logic [6:0] HEAT_OFF  = 7'(int'(TEMP_LO) + HYST);
   localparam logic [6:0] COOL_OFF  = 7'(int'(TEMP_HI) - HYST);

   if (DEB < 1 || DEB > 15 || MIN_HOLD < 1 || MIN_HOLD > 255 ||
       int'(TEMP_LO) + HYST > int'(TEMP_HI) - HYST) begin : g_bad_params
      $error("home_event_scheduler: illegal parameter set");
   end

   state_t     state_q, state_d, win;
   logic [3:0] raw, deb_q, deb_d;
   logic [3:0] cnt_q [4];
   logic [3:0] cnt_d [4];
   logic       heat_q, heat_d, cool_q, cool_d, gc_q;
   logic [7:0] hold_q, hold_d;

   function automatic logic [2:0] rank(input state_t s);
      case (s)
         S_ALARM:  rank = 3'd6;
         S_FDOOR:  rank = 3'd5;
         S_RDOOR:  rank = 3'd4;
         S_WINDOW: rank = 3'd3;
         S_HEAT:   rank = 3'd2;
         S_COOL:   rank = 3'd1;
         default:  rank = 3'd0;
      endcase
   endfunction

   assign raw = {SFA, SW, SRD, SFD};

   always_comb begin
      deb_d = deb_q;
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = 4'd0;
         if (raw[k] != deb_q[k]) begin
            if (cnt_q[k] == DEB_LAST) deb_d[k] = raw[k];
            else cnt_d[k] = cnt_q[k] + 4'd1;
         end
      end
   end

   // Inside the hysteresis band the previous request is kept.
   assign heat_d = (ST < TEMP_LO) ? 1'b1 : (ST >= HEAT_OFF) ? 1'b0 : heat_q;
   assign cool_d = (ST > TEMP_HI) ? 1'b1 : (ST <= COOL_OFF) ? 1'b0 : cool_q;

   assign win = deb_q[3] ? S_ALARM  :
                deb_q[0] ? S_FDOOR  :
                deb_q[1] ? S_RDOOR  :
                deb_q[2] ? S_WINDOW :
                heat_q   ? S_HEAT   :
                cool_q   ? S_COOL   : S_IDLE;

   always_comb begin
      state_d = state_q;
      if (state_q == S_BAD) state_d = S_IDLE;
      else if (rank(win) > rank(state_q) || hold_q == 8'd0) state_d = win;
`ifdef ALARM_LATCH_EN
      if (state_q == S_ALARM) state_d = (alarm_ack && !deb_q[3]) ? win : S_ALARM;
`endif
      hold_d = (state_d != state_q) ? ((state_d == S_IDLE) ? 8'd0 : HOLD_LOAD) :
               (hold_q != 8'd0) ? hold_q - 8'd1 : 8'd0;
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         deb_q   <= 4'd0;
         cnt_q   <= '{default: 4'd0};
         hold_q  <= 8'd0;
         heat_q  <= 1'b0;
         cool_q  <= 1'b0;
         gc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         heat_q  <= heat_d;
         cool_q  <= cool_d;
         gc_q    <= state_d != state_q;
      end
   end

   assign fdoor       = state_q == S_FDOOR;
   assign rdoor       = state_q == S_RDOOR;
   assign alarmbuzz   = state_q == S_ALARM;
   assign winbuzz     = state_q == S_WINDOW;
   assign heater      = state_q == S_HEAT;
   assign cooler      = state_q == S_COOL;
   assign display     = state_q;
   assign grant_chg   = gc_q;
   assign hold_active = hold_q != 8'd0;
endmodule

// File: tb/tb_home_event_scheduler.sv
// tb_home_event_scheduler: directed stimulus with a cycle-tagged expectation queue drained by a negedge monitor.
module tb_home_event_scheduler;
   logic       clk = 1'b0;
   logic       Rst, SFD, SRD, SW, SFA;
   logic [6:0] ST;
`ifdef ALARM_LATCH_EN
   logic       alarm_ack;
`endif
   logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, grant_chg, hold_active;
   logic [2:0] display;

   typedef struct {
      int         cyc;
      string      nm;
      logic [2:0] disp;
      logic       gc;
      logic       ha;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   edges = 0;
   int   checks = 0;
   int   passed = 0;

   home_event_scheduler dut (
      .clk(clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
`ifdef ALARM_LATCH_EN
      .alarm_ack(alarm_ack),
`endif
      .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz), .alarmbuzz(alarmbuzz),
      .heater(heater), .cooler(cooler), .display(display),
      .grant_chg(grant_chg), .hold_active(hold_active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   // actuator order: {cooler, heater, alarmbuzz, winbuzz, rdoor, fdoor}
   function automatic logic [5:0] exp_act(input logic [2:0] code);
      case (code)
         3'd1:    exp_act = 6'b000001;
         3'd2:    exp_act = 6'b000010;
         3'd3:    exp_act = 6'b001000;
         3'd4:    exp_act = 6'b000100;
         3'd5:    exp_act = 6'b010000;
         3'd6:    exp_act = 6'b100000;
         default: exp_act = 6'b000000;
      endcase
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got == want) passed++;
      else $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
   endtask

   task automatic expect_in(input int d, input string nm, input logic [2:0] disp,
                            input logic gc, input logic ha);
      sb.push_back('{edges + d, nm, disp, gc, ha});
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= edges) begin
         cur = sb.pop_front();
         chk({cur.nm, "_disp_act"},
             int'({display, cooler, heater, alarmbuzz, winbuzz, rdoor, fdoor}),
             int'({cur.disp, exp_act(cur.disp)}));
         chk({cur.nm, "_grant_chg"}, int'(grant_chg), int'(cur.gc));
         chk({cur.nm, "_hold_active"}, int'(hold_active), int'(cur.ha));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      Rst = 1'b1; SFD = 1'b1; SRD = 1'b1; SW = 1'b1; SFA = 1'b1; ST = 7'd60;
`ifdef ALARM_LATCH_EN
      alarm_ack = 1'b0;
`endif
      expect_in(1, "reset_e1", 3'd0, 1'b0, 1'b0);
      expect_in(2, "reset_e2", 3'd0, 1'b0, 1'b0);
      tick(2);
      Rst = 1'b0; SFD = 1'b0; SRD = 1'b0; SW = 1'b0; SFA = 1'b0;
      expect_in(3, "idle", 3'd0, 1'b0, 1'b0);
      tick(3);
      // front door debounce, then fire alarm preempts with hold still running
      SFD = 1'b1;
      expect_in(3, "deb_wait", 3'd0, 1'b0, 1'b0);
      expect_in(4, "deb_fdoor", 3'd1, 1'b1, 1'b1);
      expect_in(5, "fdoor_hold", 3'd1, 1'b0, 1'b1);
      expect_in(6, "preempt_alarm", 3'd3, 1'b1, 1'b1);
      tick(2);
      SFA = 1'b1;
      tick(4);
      SFA = 1'b0; SFD = 1'b0; SRD = 1'b1;
      expect_in(1, "alarm_stay", 3'd3, 1'b0, 1'b1);
      expect_in(7, "alarm_hold0", 3'd3, 1'b0, 1'b0);
`ifdef ALARM_LATCH_EN
      expect_in(8, "alarm_latched", 3'd3, 1'b0, 1'b0);
      tick(8);
      alarm_ack = 1'b1;
      expect_in(1, "ack_rdoor", 3'd2, 1'b1, 1'b1);
      tick(1);
      alarm_ack = 1'b0;
`else
      expect_in(8, "rdoor_after_hold", 3'd2, 1'b1, 1'b1);
      tick(8);
`endif
      // reset in the middle of a hold
      Rst = 1'b1; SRD = 1'b0;
      expect_in(1, "rst_mid_hold", 3'd0, 1'b0, 1'b0);
      tick(1);
      Rst = 1'b0;
      tick(1);
      // two-cycle glitch is filtered
      SFD = 1'b1;
      expect_in(3, "glitch_a", 3'd0, 1'b0, 1'b0);
      expect_in(6, "glitch_b", 3'd0, 1'b0, 1'b0);
      tick(2);
      SFD = 1'b0;
      tick(4);
      // heat first, window preempts, window held 8 cycles, then heat resumes
      SW = 1'b1; ST = 7'd49;
      expect_in(1, "heat_wait", 3'd0, 1'b0, 1'b0);
      expect_in(2, "heat_on", 3'd5, 1'b1, 1'b1);
      expect_in(3, "heat_hold", 3'd5, 1'b0, 1'b1);
      expect_in(4, "window_preempt", 3'd4, 1'b1, 1'b1);
      tick(6);
      SW = 1'b0;
      expect_in(5, "window_last", 3'd4, 1'b0, 1'b0);
      expect_in(6, "heat_resume", 3'd5, 1'b1, 1'b1);
      tick(6);
      // hysteresis: 51 keeps heating, 52 releases after the hold
      ST = 7'd51;
      expect_in(3, "hyst_51", 3'd5, 1'b0, 1'b1);
      tick(3);
      ST = 7'd52;
      expect_in(3, "hyst_52_hold", 3'd5, 1'b0, 1'b1);
      expect_in(4, "hyst_52_last", 3'd5, 1'b0, 1'b0);
      expect_in(5, "hyst_idle", 3'd0, 1'b1, 1'b0);
      tick(5);
      // cooling with upper band
      ST = 7'd71;
      expect_in(1, "cool_wait", 3'd0, 1'b0, 1'b0);
      expect_in(2, "cool_on", 3'd6, 1'b1, 1'b1);
      tick(2);
      ST = 7'd69;
      expect_in(10, "cool_band", 3'd6, 1'b0, 1'b0);
      tick(10);
      ST = 7'd68;
      expect_in(1, "cool_release", 3'd6, 1'b0, 1'b0);
      expect_in(2, "cool_idle", 3'd0, 1'b1, 1'b0);
      tick(2);
      // thresholds themselves raise no request
      ST = 7'd70;
      expect_in(3, "st_70", 3'd0, 1'b0, 1'b0);
      tick(3);
      ST = 7'd50;
      expect_in(3, "st_50", 3'd0, 1'b0, 1'b0);
      tick(5);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
